// File: rtl/hera_store_uart_tx_if.sv
// hera_store_uart_tx_if
// Data-RAM store bus as seen by the store tracer.
//   st_we   : store strobe, one store per cycle while high
//   st_addr : 12-bit store address
//   st_data : 16-bit store data
// Handshake: the bus has no back-pressure. Every cycle with st_we high is one
// store offered to the slave. The slave either buffers it or counts it as
// dropped. The master never waits.
// master : the CPU side driving the store bus.
// slave  : the tracer that snoops it.
interface hera_store_uart_tx_if;
    logic        st_we;
    logic [11:0] st_addr;
    logic [15:0] st_data;

    modport master (output st_we, st_addr, st_data);
    modport slave  (input  st_we, st_addr, st_data);
endinterface

// File: rtl/hera_store_uart_tx.sv
// hera_store_uart_tx
// Snoops data-RAM stores while the CPU runs and buffers them in a small FIFO.
// Each store is sent as a 5-byte 8N1 UART packet so a host terminal can trace
// program writes. Packet bytes: SYNC_BYTE, {4'h0, addr[11:8]}, addr[7:0],
// data[15:8], data[7:0].
// Ports:
//   clk        : system clock
//   hard_rst   : asynchronous, active-low reset
//   run_en     : CPU run mode; stores are captured only while high
//   store      : store bus (slave modport of hera_store_uart_tx_if)
//   host_ready : a new packet may start only while high (sampled in IDLE)
//   tx         : UART serial output, idle high
//   busy       : packet in flight or FIFO non-empty (registered)
//   overflow   : sticky; set when a store is dropped on a full FIFO
//   drop_cnt   : dropped-store count, saturating at 255
//   fsm_state  : current transmit FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module hera_store_uart_tx #(
    parameter int         CLKS_PER_BIT = 417,
    parameter int         FIFO_AW      = 3,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                    clk,
    input  logic                    hard_rst,
    input  logic                    run_en,
    hera_store_uart_tx_if.slave     store,
    input  logic                    host_ready,
    output logic                    tx,
    output logic                    busy,
    output logic                    overflow,
    output logic [7:0]              drop_cnt,
    output logic [1:0]              fsm_state
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t state;

    // FIFO storage and pointers. Pointers carry one extra wrap bit so full
    // and empty can be told apart without a separate count.
    logic [27:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push_req;
    logic             push_ok;
    logic             pop;

    // Transmit datapath
    logic [27:0]      pkt;
    logic [2:0]       byte_idx;
    logic [2:0]       bit_idx;
    logic [BW-1:0]    baud_cnt;
    logic [7:0]       cur_byte;
    logic             baud_end;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    assign pop      = (state == ST_IDLE) && !empty && host_ready;
    assign push_req = run_en && store.st_we;
    // A full FIFO still accepts a store when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign fsm_state = state;

    always_comb begin
        cur_byte = pkt[7:0];
        case (byte_idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = {4'h0, pkt[27:24]};
            3'd2:    cur_byte = pkt[23:16];
            3'd3:    cur_byte = pkt[15:8];
            default: cur_byte = pkt[7:0];
        endcase
    end

    // FIFO storage has no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {store.st_addr, store.st_data};
        end
    end

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
            busy     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
            busy <= (state != ST_IDLE) || !empty;
        end
    end

    // Transmit FSM. tx is registered from the current state, so the line
    // trails the state by one cycle. Every bit still lasts exactly
    // CLKS_PER_BIT cycles on the pin.
    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            pkt      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        pkt      <= mem[rd_ptr[FIFO_AW-1:0]];
                        byte_idx <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    tx <= 1'b0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    tx <= cur_byte[bit_idx];
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx < 3'd4) begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
